// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
// Holds the controller state enum and default address-map parameters.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int          SRAM_DW       = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int          DEF_SRAM_AW   = 18;

endpackage

// File: rtl/sram_controller.sv
// Memory-stage controller: splits 32-bit loads/stores into two 16-bit
// asynchronous SRAM accesses, low half first, stalling via ready.
// Ports: clk, rst (sync, active-high); rd_en, wr_en, address, wr_data
// from the MEM stage; rd_data, ready to the pipeline; sram_addr,
// sram_dq_out, sram_dq_in, sram_dq_oe, sram_we_n to the SRAM pins
// (the tristate buffer lives at the top level).
// Optional SRAM_ADDR_CHECK_EN adds addr_err and rejects out-of-range
// requests without touching the SRAM; otherwise addresses truncate.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = DEF_SRAM_AW,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
`ifdef SRAM_ADDR_CHECK_EN
    output logic               addr_err,
`endif
    output logic               sram_we_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                op_wr;
    logic [SRAM_AW-2:0]  word_q;
    logic [31:0]         data_q;

    logic [31:0]         off;
    logic [SRAM_AW-2:0]  word;
    logic                in_range;
    logic                req;
    logic                unused_off;

    assign off  = address - BASE_ADDR;
    assign word = off[SRAM_AW:2];
    assign req  = rd_en | wr_en;

    // Byte offset bits and (without the check) the upper bits are dropped.
    assign unused_off = ^{off[1:0], off[31:SRAM_AW+1]};

`ifdef SRAM_ADDR_CHECK_EN
    assign in_range = (address >= BASE_ADDR) &&
                      (off[31:SRAM_AW+1] == '0);
`else
    assign in_range = 1'b1;
`endif

    assign ready = (state == IDLE && !req) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else begin
`ifdef SRAM_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_wr  <= wr_en;
                        word_q <= word;
                        data_q <= wr_data;
                        cnt    <= '0;
                        if (in_range) begin
                            // Pins are set up on this edge so the low
                            // half is held for the full LOW window.
                            state       <= LOW;
                            sram_addr   <= {word, 1'b0};
                            sram_dq_out <= wr_data[15:0];
                            sram_dq_oe  <= wr_en;
                            sram_we_n   <= ~wr_en;
                        end else begin
                            state <= DONE;
                            if (!wr_en) rd_data <= '0;
`ifdef SRAM_ADDR_CHECK_EN
                            addr_err <= 1'b1;
`endif
                        end
                    end
                end
                LOW: begin
                    if (cnt == CNT_MAX) begin
                        if (!op_wr) rd_data[15:0] <= sram_dq_in;
                        cnt         <= '0;
                        state       <= HIGH;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= data_q[31:16];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == CNT_MAX) begin
                        if (!op_wr) rd_data[31:16] <= sram_dq_in;
                        cnt        <= '0;
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM.
// Table-driven cycle vectors plus hand sequences for reset and range.
module tb_sram_controller;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    logic [15:0] mem [0:262143];
    int          run = 0;
    logic [17:0] run_addr = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr];

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
`ifdef SRAM_ADDR_CHECK_EN
        .addr_err   (addr_err),
`endif
        .sram_we_n  (sram_we_n)
    );

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] addr, wd;
        logic        chk;
        logic        e_ready, e_we_n, e_oe;
        logic [17:0] e_sa;
        logic [15:0] e_dq;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic rd, input logic wr,
        input logic [31:0] a, input logic [31:0] wd,
        input logic c, input logic er, input logic ew,
        input logic eo, input logic [17:0] sa,
        input logic [15:0] dq, input logic [31:0] erd);
        vec_t v;
        v.rst = rs; v.rd = rd; v.wr = wr;
        v.addr = a; v.wd = wd; v.chk = c;
        v.e_ready = er; v.e_we_n = ew; v.e_oe = eo;
        v.e_sa = sa; v.e_dq = dq; v.e_rd = erd;
        return v;
    endfunction

    // SRAM commits a write only once we_n has been low on the same
    // address for a full WAIT-cycle window.
    task automatic model_update();
        if (sram_we_n == 1'b0) begin
            if (run > 0 && sram_addr == run_addr) run++;
            else run = 1;
            run_addr = sram_addr;
            if (run == WAIT) mem[sram_addr] = sram_dq_out;
        end else begin
            run = 0;
        end
    endtask

    task automatic drive(input logic rs, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst = rs; rd_en = rd; wr_en = wr; address = a; wr_data = wd;
        #1;
        model_update();
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        bit got_ready;
        int we_low;

        for (int i = 0; i < 262144; i++) mem[i] = '0;

        vecs.push_back(mk(1,0,1,1032,32'hDEADBEEF,0, 0,1,0,0,0,0));
        vecs.push_back(mk(1,0,1,1032,32'hDEADBEEF,1, 0,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,1032,32'hDEADBEEF,1, 0,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,1, 0,0,1,4,16'hBEEF,0));
        vecs.push_back(mk(0,1,1,8,32'hFFFFFFFF,1, 0,0,1,4,16'hBEEF,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,5,16'hDEAD,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,5,16'hDEAD,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,1,0,5,0,0));
        vecs.push_back(mk(0,1,0,1032,0,1, 0,1,0,5,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,1,0,4,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,1,0,4,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,1,0,5,0,32'h0000BEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 0,1,0,5,0,32'h0000BEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 1,1,0,5,0,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 1,1,0,5,0,32'hDEADBEEF));
        vecs.push_back(mk(0,1,1,1043,32'h12345678,1,
                          0,1,0,5,0,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,8,16'h5678,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,8,16'h5678,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,9,16'h1234,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,9,16'h1234,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 1,1,0,9,0,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,1, 1,1,0,9,0,32'hDEADBEEF));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr,
                  vecs[i].addr, vecs[i].wd);
            if (vecs[i].chk) begin
                check($sformatf("v%0d ready", i),
                      {31'b0, ready}, {31'b0, vecs[i].e_ready});
                check($sformatf("v%0d we_n", i),
                      {31'b0, sram_we_n}, {31'b0, vecs[i].e_we_n});
                check($sformatf("v%0d oe", i),
                      {31'b0, sram_dq_oe}, {31'b0, vecs[i].e_oe});
                check($sformatf("v%0d sram_addr", i),
                      {14'b0, sram_addr}, {14'b0, vecs[i].e_sa});
                check($sformatf("v%0d rd_data", i),
                      rd_data, vecs[i].e_rd);
                if (!vecs[i].e_we_n)
                    check($sformatf("v%0d dq_out", i),
                          {16'b0, sram_dq_out}, {16'b0, vecs[i].e_dq});
            end
        end
        check("mem4", {16'b0, mem[4]}, 32'h0000BEEF);
        check("mem5", {16'b0, mem[5]}, 32'h0000DEAD);
        check("mem8", {16'b0, mem[8]}, 32'h00005678);
        check("mem9", {16'b0, mem[9]}, 32'h00001234);

        // Reset during the first HIGH cycle of a store.
        mem[10] = 16'h2222;
        mem[11] = 16'h1111;
        drive(0, 0, 1, 1044, 32'hCAFEF00D);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("rst_mid high addr", {14'b0, sram_addr}, 32'd11);
        drive(0, 0, 0, 0, 0);
        check("rst_mid ready", {31'b0, ready}, 32'd1);
        check("rst_mid we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_mid oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rst_mid sram_addr", {14'b0, sram_addr}, 32'd0);
        check("rst_mid rd_data", rd_data, 32'd0);
        check("rst_mid mem10", {16'b0, mem[10]}, 32'h0000F00D);
        check("rst_mid mem11", {16'b0, mem[11]}, 32'h00001111);

        // Give rd_data a nonzero value before the range test.
        drive(0, 1, 0, 1032, 0);
        got_ready = 1'b0;
        for (int k = 0; k < 20 && !got_ready; k++) begin
            drive(0, 0, 0, 0, 0);
            got_ready = ready;
        end
        check("reload done", {31'b0, got_ready}, 32'd1);
        check("reload rd_data", rd_data, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0);

        // Load below BASE_ADDR.
        mem[18'h3FF00] = 16'h5A5A;
        mem[18'h3FF01] = 16'hA5A5;
        drive(0, 1, 0, 512, 0);
        check("low_addr req ready", {31'b0, ready}, 32'd0);
`ifdef SRAM_ADDR_CHECK_EN
        drive(0, 0, 0, 0, 0);
        check("err ready", {31'b0, ready}, 32'd1);
        check("err addr_err", {31'b0, addr_err}, 32'd1);
        check("err rd_data", rd_data, 32'd0);
        check("err we_n", {31'b0, sram_we_n}, 32'd1);
        check("err oe", {31'b0, sram_dq_oe}, 32'd0);
        drive(0, 0, 0, 0, 0);
        check("err clear", {31'b0, addr_err}, 32'd0);
`else
        got_ready = 1'b0;
        we_low = 0;
        for (int k = 0; k < 20 && !got_ready; k++) begin
            drive(0, 0, 0, 0, 0);
            if (!sram_we_n) we_low++;
            got_ready = ready;
        end
        check("alias done", {31'b0, got_ready}, 32'd1);
        check("alias rd_data", rd_data, 32'hA5A55A5A);
        check("alias no strobe", we_low, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-stage block between the EXE/MEM pipeline register and the MEM/WB pipeline register.
- Replaces the single-cycle data memory with an off-chip 16-bit asynchronous SRAM interface.
- Each 32-bit load or store is split into two 16-bit SRAM accesses.
- `ready` is deasserted while an access is in flight; the top level ORs `~ready` into the pipeline freeze.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; subtracted from `address`.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: cycles each 16-bit half access is held on the pins; legal range ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rd_en  in  1  load request (from mem_r_en of the MEM stage).
- wr_en  in  1  store request (from mem_w_en of the MEM stage).
- address  in  32  byte address (ALU result).
- wr_data  in  32  store data (val_rm).
- rd_data  out  32  load result; valid when `ready`=1 in DONE.
- ready  out  1  1 = no access pending or access completing this cycle.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  drive enable for the top-level tristate.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is `rst`, synchronous and active-high.
- Reset values:
  - state = IDLE, cnt = 0.
  - sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
  - rd_data = 0.
  - Latched op/addr/data cleared.
- Address map:
  - off = address − BASE_ADDR (32-bit, wraps modulo 2^32).
  - word = off[SRAM_AW:2].
  - Low half at sram_addr = {word,0}; high half at {word,1}. Bits [1:0] are ignored.
- `ready` is combinational: `(state==IDLE && !(rd_en||wr_en)) || state==DONE`.
- States:
  - IDLE: on rd_en|wr_en, latch op, word and wr_data; cnt ← 0; go to LOW. If both are asserted, write wins.
  - LOW: drive sram_addr={word,0}.
    - Write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0 for all WAIT_CYCLES cycles.
    - Read: sram_dq_oe = 0, sram_we_n = 1.
    - On cnt==WAIT_CYCLES−1: a read captures rd_data[15:0] ← sram_dq_in; cnt ← 0; go to HIGH. Otherwise cnt++.
  - HIGH: same as LOW with {word,1} and bits [31:16]; go to DONE.
  - DONE: one cycle; sram_we_n = 1, sram_dq_oe = 0; go to IDLE unconditionally.
- Latency: a request in cycle 0 gives ready = 0 for cycles 0 … 2·WAIT_CYCLES; ready = 1 in cycle 2·WAIT_CYCLES+1 (DONE). WAIT_CYCLES=2 gives 5 stall cycles and ready in cycle 5.
- Back-to-back requests: the pipeline advances on the DONE edge. A request present in the following IDLE cycle is a new instruction and starts immediately.
- Request inputs are ignored outside IDLE; the latched values are used.
- rd_data holds its value until the next read's captures; writes do not alter it.
- sram_we_n returns high for at least one cycle (DONE) between consecutive writes.
- `rst` in any state: return to IDLE next edge with reset values. A partial write may leave the SRAM half-updated; this is acceptable.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- Defined:
  - Adds output `addr_err` (1 bit, reset 0).
  - If off ≥ 2^(SRAM_AW+1), or address < BASE_ADDR, the request skips LOW/HIGH and goes directly to DONE. No SRAM strobes are issued; rd_data ← 0 for reads; addr_err = 1 during that DONE cycle only.
- Undefined: no port and no check. Out-of-range addresses alias via truncation.

Decomposition:
- Shared package arm_mem_pkg holds:
  - state enum {IDLE, LOW, HIGH, DONE} (2-bit);
  - SRAM data width 16;
  - default BASE_ADDR 1024;
  - default SRAM_AW 18.
- The tristate buffer lives at the top level, not in this block.
- No sub-module is natural: the FSM plus wait counter is one module.

Test Plan:
- Reset: assert rst for 2 cycles with wr_en=1 → sram_we_n=1, sram_dq_oe=0, rd_data=0; ready=0 only because wr_en is high.
- Store: wr_en with address=1032, wr_data=0xDEADBEEF, WAIT_CYCLES=2 → addr 4 written with 0xBEEF (we_n low 2 cycles), then addr 5 with 0xDEAD; ready low cycles 0–4, high cycle 5.
- Load: rd_en at address=1032 with the SRAM model from the store test → rd_data=0xDEADBEEF in the DONE cycle; sram_we_n never low.
- Back-to-back: store then load issued in the cycle after DONE → second access starts without an idle gap; 11 total cycles from first request to second ready.
- Reset mid-write: rst asserted in HIGH cycle 1 → next cycle IDLE, we_n=1, oe=0; addr 5 is not written.
- SRAM_ADDR_CHECK_EN: rd_en at address=512 → ready=1 next cycle with addr_err=1, rd_data=0, no SRAM strobe. Without the macro, the same stimulus builds, and rd_data is the SRAM word at the truncated address.
